// File: rtl/icache_arb.sv
`default_nettype none
// ============================================================================
// Module      : icache_arb
// Description : Two-requester arbiter (fetch, loader) in front of a
//               single-port instruction cache with 1-cycle read latency.
//               Combinational grants, starvation guard for the loader,
//               and read-valid steering back to the requester that owns
//               the in-flight read.
//               Optional macro ICACHE_ARB_LOCK_EN: when defined, l_lock
//               gives the loader exclusive access and holds fetch off.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_arb #(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_en,
  input  logic [ADDR_W-1:0] f_index,
  output logic              f_gnt,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_rvalid,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_index,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_rvalid,
  output logic              icache_en,
  output logic              icache_we,
  output logic [ADDR_W-1:0] icache_index,
  output logic [DATA_W-1:0] icache_wdata,
  input  logic [DATA_W-1:0] icache_rdata,
  input  logic              icache_rvalid
);

  localparam logic [3:0] C_STARVE_CNT = 4'(STARVE_LIMIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       pending_q, pending_d;
  logic       owner_q, owner_d;
  logic       lock_act;
  logic       starved;

`ifdef ICACHE_ARB_LOCK_EN
  assign lock_act = l_lock;
`else
  logic unused_lock;
  assign lock_act    = 1'b0;
  assign unused_lock = l_lock;
`endif

  assign starved = l_req && (wait_cnt_q == C_STARVE_CNT);

  // Fixed-priority grant: lock > starved loader > fetch > loader; nothing while in reset.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (lock_act) begin
        l_gnt = l_req;
      end else if (starved) begin
        l_gnt = 1'b1;
      end else if (f_en) begin
        f_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  // Cache-side request mux; all fields forced to zero on idle cycles.
  always_comb begin
    icache_en    = f_gnt | l_gnt;
    icache_we    = l_gnt & l_we;
    icache_index = '0;
    icache_wdata = '0;
    if (f_gnt) begin
      icache_index = f_index;
    end else if (l_gnt) begin
      icache_index = l_index;
      icache_wdata = l_wdata;
    end
  end

  // Next-state: loader wait counter and ownership of the in-flight read.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!l_req || l_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < C_STARVE_CNT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    pending_d = f_gnt | (l_gnt & ~l_we);
    owner_d   = l_gnt;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      pending_q  <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
      owner_q    <= owner_d;
    end
  end

  // Read return: data fans out to both, valid goes only to the owner.
  assign f_rdata  = icache_rdata;
  assign l_rdata  = icache_rdata;
  assign f_rvalid = ~rst & icache_rvalid & pending_q & ~owner_q;
  assign l_rvalid = ~rst & icache_rvalid & pending_q &  owner_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_arb
// Description : Directed-vector bench for icache_arb with a behavioural
//               1-cycle-latency cache and a read-data scoreboard.
//               Honours ICACHE_ARB_LOCK_EN for the lock scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_en;
  logic [29:0] f_index;
  logic        f_gnt;
  logic [31:0] f_rdata;
  logic        f_rvalid;
  logic        l_req, l_we, l_lock;
  logic [29:0] l_index;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic [31:0] l_rdata;
  logic        l_rvalid;
  logic        icache_en, icache_we;
  logic [29:0] icache_index;
  logic [31:0] icache_wdata;
  logic [31:0] icache_rdata;
  logic        icache_rvalid;

  logic [31:0] mem [16];
  logic [31:0] c_rdata;
  logic        c_rvalid;
  logic        extra_rvalid;

  int vec  = 0;
  int errs = 0;
  logic [31:0] fq[$];
  logic [31:0] lq[$];

  always #5 clk = ~clk;

  icache_arb #(.ADDR_W(30), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_en(f_en), .f_index(f_index), .f_gnt(f_gnt), .f_rdata(f_rdata), .f_rvalid(f_rvalid),
    .l_req(l_req), .l_we(l_we), .l_index(l_index), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
    .icache_en(icache_en), .icache_we(icache_we), .icache_index(icache_index),
    .icache_wdata(icache_wdata), .icache_rdata(icache_rdata), .icache_rvalid(icache_rvalid)
  );

  // Cache model: mem[i] = 0x1000_0000 + i after reset, one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      c_rvalid <= 1'b0;
      c_rdata  <= 32'h0;
    end else begin
      c_rvalid <= icache_en & ~icache_we;
      if (icache_en & icache_we) mem[icache_index[3:0]] <= icache_wdata;
      else if (icache_en) c_rdata <= mem[icache_index[3:0]];
    end
  end
  assign icache_rdata  = c_rdata;
  assign icache_rvalid = c_rvalid | extra_rvalid;

  // Scoreboard monitor: every presented rvalid must match the oldest expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (f_rvalid && l_rvalid) begin
      vec++; errs++;
      $display("FAIL both_rvalid: f_rvalid=1 l_rvalid=1, required at most one");
    end
    if (f_rvalid) begin
      vec++;
      if (fq.size() == 0) begin
        errs++;
        $display("FAIL f_unexpected: f_rvalid=1 data=%h, required no fetch rvalid", f_rdata);
      end else begin
        e = fq.pop_front();
        if (f_rdata !== e) begin
          errs++;
          $display("FAIL f_rdata: got %h required %h", f_rdata, e);
        end
      end
    end
    if (l_rvalid) begin
      vec++;
      if (lq.size() == 0) begin
        errs++;
        $display("FAIL l_unexpected: l_rvalid=1 data=%h, required no loader rvalid", l_rdata);
      end else begin
        e = lq.pop_front();
        if (l_rdata !== e) begin
          errs++;
          $display("FAIL l_rdata: got %h required %h", l_rdata, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    vec++;
    if (got !== req) begin
      errs++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // One cycle of stimulus: drive, check grants and cache strobes, queue expected read data.
  task automatic cyc(input string name, input logic fe, input logic [3:0] fi,
                     input logic lr, input logic lwe, input logic [3:0] li,
                     input logic [31:0] lwd, input logic lk,
                     input logic efg, input logic elg, input logic [31:0] edat);
    logic [29:0] eidx;
    @(posedge clk); #1;
    f_en = fe; f_index = {26'd0, fi};
    l_req = lr; l_we = lwe; l_index = {26'd0, li}; l_wdata = lwd; l_lock = lk;
    @(negedge clk);
    eidx = efg ? {26'd0, fi} : (elg ? {26'd0, li} : 30'd0);
    chk({name, "_gnt"}, {62'd0, f_gnt, l_gnt}, {62'd0, efg, elg});
    chk({name, "_cache"}, {icache_en, icache_we, icache_index},
        {1'b0, 1'b0, 1'b0, efg | elg, elg & lwe, eidx});
    if (elg && lwe) chk({name, "_wdata"}, {32'd0, icache_wdata}, {32'd0, lwd});
    if (efg) fq.push_back(edat);
    if (elg && !lwe) lq.push_back(edat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {f_gnt, l_gnt, f_rvalid, l_rvalid, icache_en, icache_we, icache_index, icache_wdata},
        64'd0);
  endtask

  initial begin
    rst = 1'b1; f_en = 1'b0; f_index = '0; l_req = 1'b0; l_we = 1'b0;
    l_index = '0; l_wdata = '0; l_lock = 1'b0; extra_rvalid = 1'b0;

    // Reset state with requests asserted: everything must stay zero.
    @(posedge clk); #1;
    f_en = 1'b1; l_req = 1'b1; l_we = 1'b1; l_wdata = 32'hFFFF_FFFF; l_index = 30'd7;
    @(negedge clk);
    chk_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0; f_en = 1'b0; l_req = 1'b0; l_we = 1'b0; l_wdata = '0; l_index = '0;

    // Continuous fetch 0..4, no loader.
    for (int i = 0; i < 5; i++)
      cyc("fetch_stream", 1, 4'(i), 0, 0, 0, 0, 0, 1, 0, 32'h1000_0000 + 32'(i));
    idle(2);

    // Stray cache rvalid with nothing pending is dropped.
    @(posedge clk); #1; extra_rvalid = 1'b1;
    @(negedge clk);
    chk("drop_stray", {62'd0, f_rvalid, l_rvalid}, 64'd0);
    @(posedge clk); #1; extra_rvalid = 1'b0;

    // Loader write idx 3, fetch read idx 3 on the next cycle.
    cyc("ld_write", 0, 0, 1, 1, 3, 32'hDEAD_BEEF, 0, 0, 1, 0);
    cyc("rd_after_wr", 1, 3, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
    idle(2);

    // Alternating fetch idx1 / loader read idx2, back-to-back.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cyc("alt_f", 1, 1, 0, 0, 0, 0, 0, 1, 0, 32'h1000_0001);
      else            cyc("alt_l", 0, 0, 1, 0, 2, 0, 0, 0, 1, 32'h1000_0002);
    end
    idle(2);

    // Continuous contention: loader wins every 5th cycle.
    for (int c = 1; c <= 15; c++) begin
      if (c % 5 == 0) cyc("starve_l", 1, 4, 1, 0, 2, 0, 0, 0, 1, 32'h1000_0002);
      else            cyc("starve_f", 1, 4, 1, 0, 2, 0, 0, 1, 0, 32'h1000_0004);
    end
    idle(2);

    // Lock asserted six cycles with fetch requesting and no loader request.
    for (int c = 0; c < 6; c++) begin
`ifdef ICACHE_ARB_LOCK_EN
      cyc("lock_hold", 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
`else
      cyc("lock_ignored", 1, 5, 0, 0, 0, 0, 1, 1, 0, 32'h1000_0005);
`endif
    end
    cyc("lock_release", 1, 5, 0, 0, 0, 0, 0, 1, 0, 32'h1000_0005);
    idle(2);

    // Build up loader wait count to the limit, then reset mid-read.
    for (int c = 0; c < 3; c++) cyc("pre_rst", 1, 0, 1, 0, 2, 0, 0, 1, 0, 32'h1000_0000);
    @(posedge clk); #1;
    f_en = 1'b1; f_index = 30'd6; l_req = 1'b1; l_we = 1'b0; l_index = 30'd2;
    @(negedge clk);
    chk("pre_rst_last_gnt", {62'd0, f_gnt, l_gnt}, {62'd0, 1'b1, 1'b0});
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midread_reset");
    @(posedge clk); #1; rst = 1'b0; f_en = 1'b0; l_req = 1'b0;
    // Wait count must restart from zero: loader only wins on the 5th cycle.
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) cyc("post_rst_l", 1, 1, 1, 0, 2, 0, 0, 0, 1, 32'h1000_0002);
      else        cyc("post_rst_f", 1, 1, 1, 0, 2, 0, 0, 1, 0, 32'h1000_0001);
    end
    idle(3);

    chk("fq_drained", 64'(fq.size()), 64'd0);
    chk("lq_drained", 64'(lq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_arb.md
ICACHE_ARB -- requirements
Module: icache_arb

Interface
REQ-001 Parameter ADDR_W, default 30, word-index width (byte address bits [31:2]).
REQ-002 Parameter DATA_W, default 32, instruction/data word width.
REQ-003 Parameter STARVE_LIMIT, default 4, loader wait cycles before forced grant (legal range 1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset: synchronous, active-high.
REQ-006 f_en  input  1  fetch read request.
REQ-007 f_index  input  ADDR_W  fetch word index.
REQ-008 f_gnt  output  1  fetch request accepted this cycle.
REQ-009 f_rdata  output  DATA_W  read data to fetch.
REQ-010 f_rvalid  output  1  f_rdata valid.
REQ-011 l_req  input  1  loader request.
REQ-012 l_we  input  1  loader request is a write.
REQ-013 l_index  input  ADDR_W  loader word index.
REQ-014 l_wdata  input  DATA_W  loader write data.
REQ-015 l_lock  input  1  loader exclusive-access request (see Configuration).
REQ-016 l_gnt  output  1  loader request accepted this cycle.
REQ-017 l_rdata  output  DATA_W  read data to loader.
REQ-018 l_rvalid  output  1  l_rdata valid.
REQ-019 icache_en  output  1  cache access strobe.
REQ-020 icache_we  output  1  cache write strobe.
REQ-021 icache_index  output  ADDR_W  cache word index.
REQ-022 icache_wdata  output  DATA_W  cache write data.
REQ-023 icache_rdata  input  DATA_W  cache read data, 1-cycle latency.
REQ-024 icache_rvalid  input  1  cache read data valid.

Function
REQ-025 Arbiter SHALL grant at most one requester per cycle; grants combinational, same cycle as request.
REQ-026 Priority order SHALL be: lock (if compiled in) > starved loader (wait_cnt == STARVE_LIMIT and l_req) > f_en > l_req.
REQ-027 wait_cnt (4 bits) SHALL increment when l_req && !l_gnt, saturate at STARVE_LIMIT, clear when l_gnt or !l_req.
REQ-028 Granted requester's index SHALL drive icache_index; icache_en = f_gnt | l_gnt; icache_we = l_gnt & l_we; icache_wdata = l_wdata.
REQ-029 Idle cycle: icache_en = 0, icache_we = 0, icache_index/wdata = 0.
REQ-030 Granted read SHALL set pending_q = 1 and owner_q = requester (0 fetch, 1 loader) next edge; otherwise pending_q <= 0.
REQ-031 icache_rvalid SHALL route to f_rvalid when pending_q && owner_q == 0, to l_rvalid when pending_q && owner_q == 1; never both.
REQ-032 icache_rvalid with pending_q == 0 SHALL be dropped.
REQ-033 f_rdata and l_rdata SHALL both equal icache_rdata; only valids gated.
REQ-034 Writes SHALL produce no rvalid.
REQ-035 Back-to-back reads, any owner mix, SHALL sustain one access per cycle with no bubbles.

Reset
REQ-036 While rst = 1: f_gnt, l_gnt, f_rvalid, l_rvalid, icache_en, icache_we = 0; icache_index, icache_wdata = 0.
REQ-037 Reset SHALL clear wait_cnt, pending_q, owner_q; reset mid-read suppresses that read's rvalid on the following cycle.

Configuration
REQ-038 Macro ICACHE_ARB_LOCK_EN defined: l_lock = 1 SHALL force f_gnt = 0 and give loader every cycle it requests; fetch held off while lock asserted even if l_req = 0.
REQ-039 Macro ICACHE_ARB_LOCK_EN undefined: l_lock SHALL be ignored; priority per REQ-026 without lock term.

Verification
REQ-040 f_en = 1 continuous, indices 0..4, l_req = 0 -> f_gnt every cycle, f_rvalid 1 cycle after each, data = mem[0..4], l_rvalid never 1.
REQ-041 f_en = 1 and l_req = 1 continuous, STARVE_LIMIT = 4 -> l_gnt on cycles 5, 10, 15 (one per 5), f_gnt all others.
REQ-042 Loader write idx 3 data 0xDEADBEEF, then fetch read idx 3 next cycle -> icache_we pulse 1 cycle, f_rdata = 0xDEADBEEF, no l_rvalid.
REQ-043 Alternating fetch read idx 1 / loader read idx 2 -> f_rvalid and l_rvalid alternate each cycle with mem[1] / mem[2], never simultaneous.
REQ-044 rst asserted cycle after granted fetch read -> f_rvalid stays 0, all outputs 0, wait_cnt 0 after release.
REQ-045 With ICACHE_ARB_LOCK_EN, l_lock = 1 for 6 cycles, f_en = 1 -> f_gnt = 0 for all 6, resumes cycle after l_lock drops; without macro f_gnt every cycle.
